// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: controller state encoding and the
// TX line-mux select codes used by both the controller and the line mux.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_SEL_START = 2'b00;
  localparam logic [1:0] MUX_SEL_STOP  = 2'b01;
  localparam logic [1:0] MUX_SEL_DATA  = 2'b10;
  localparam logic [1:0] MUX_SEL_PAR   = 2'b11;

  // Line select is a pure function of state, so mux_sel never sees an input.
  function automatic logic [1:0] mux_sel_of(input tx_state_e s);
    logic [1:0] sel;
    sel = MUX_SEL_STOP;
    case (s)
      ST_START:  sel = MUX_SEL_START;
      ST_DATA:   sel = MUX_SEL_DATA;
      ST_PARITY: sel = MUX_SEL_PAR;
      default:   sel = MUX_SEL_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_bit_cnt.sv
// Data-bit counter for the UART transmitter: synchronous clear, count enable,
// terminal-count flag when the last data bit (DATA_W-1) is on the line.
module uart_bit_cnt #(
  parameter int DATA_W = 8
) (
  input  logic                      clk_parity,
  input  logic                      rst_parity,
  input  logic                      clear,
  input  logic                      en,
  output logic                      tc,
  output logic [$clog2(DATA_W)-1:0] cnt
);

  localparam int CNT_W = $clog2(DATA_W);

  always_ff @(posedge clk_parity or negedge rst_parity) begin
    if (!rst_parity) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, data, optional parity and stop
// bits one per clock. Define UART_TX_CTRL_STOP2_EN for two stop bits.
//
// Handshake: data_valid is a request with no ready; it is taken (ser_load
// pulses) only in IDLE or the final stop cycle, otherwise it is dropped.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic       clk_parity,
  input  logic       rst_parity,
  input  logic       data_valid,
  input  logic       par_en,
  input  logic       par_typ,
  output logic       ser_load,
  output logic       ser_en,
  output logic       par_calc_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_done,
  output logic       par_typ_hold,
  output tx_state_e  state_dbg
);

`ifdef UART_TX_CTRL_STOP2_EN
  localparam int STOP_CYCLES = 2;
`else
  localparam int STOP_CYCLES = 1;
`endif

  tx_state_e state;
  tx_state_e state_nxt;
  logic      par_en_q;
  logic      par_typ_q;
  logic      stop_cnt;
  logic      stop_last;
  logic      accept;
  logic      bit_tc;
  logic [$clog2(DATA_W)-1:0] bit_cnt;

  assign stop_last = (state == ST_STOP) && (stop_cnt == 1'(STOP_CYCLES - 1));
  // Gated by reset so the load pulse is also forced low while reset is held.
  assign accept    = rst_parity && data_valid && ((state == ST_IDLE) || stop_last);

  uart_bit_cnt #(
    .DATA_W (DATA_W)
  ) u_bit_cnt (
    .clk_parity (clk_parity),
    .rst_parity (rst_parity),
    .clear      (state != ST_DATA),
    .en         (state == ST_DATA),
    .tc         (bit_tc),
    .cnt        (bit_cnt)
  );

  always_ff @(posedge clk_parity or negedge rst_parity) begin
    if (!rst_parity) begin
      state     <= ST_IDLE;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop_cnt  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
      end
      if ((state == ST_STOP) && !stop_last) begin
        stop_cnt <= stop_cnt + 1'b1;
      end else begin
        stop_cnt <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_START;
      ST_START:  state_nxt = ST_DATA;
      ST_DATA:   if (bit_tc) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP: begin
        if (stop_last) state_nxt = accept ? ST_START : ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ser_load     = accept;
    par_calc_en  = accept && par_en;
    ser_en       = (state == ST_DATA);
    mux_sel      = mux_sel_of(state);
    busy         = (state != ST_IDLE);
    frame_done   = stop_last;
    par_typ_hold = par_typ_q;
    state_dbg    = state;
  end

endmodule
